// File: rtl/iob_master.sv
`timescale 1ns/1ps
// iob_master: runs 68000-style bus cycles (including 6800 VPA/E/VMA cycles)
// on the slow C8M I/O bus on behalf of the I/O bridge slave.
// Ports:
//   CLK, nRES                 fast clock, async active-low reset
//   C8M, E                    asynchronous I/O bus clocks (synchronised here)
//   IOREQ, IORW, IOL0, IOU0   transfer request from the slave side
//   nDTACK, nVPA, nBERR       I/O bus termination inputs (synchronised here)
//   IOACT, IODONE, IOBERR     status back to the slave side
//   ALE0M                     hold of the primary address/data latch
//   nASout, nLDSout, nUDSout, nVMA, RnWout, nDoutOE   I/O bus controls
module iob_master #(
  parameter int unsigned TIMEOUT = 128,
  parameter int unsigned CW      = 8
) (
  input  logic CLK,
  input  logic nRES,
  input  logic C8M,
  input  logic E,
  input  logic IOREQ,
  input  logic IORW,
  input  logic IOL0,
  input  logic IOU0,
  input  logic nDTACK,
  input  logic nVPA,
  input  logic nBERR,
  output logic IOACT,
  output logic IODONE,
  output logic IOBERR,
  output logic ALE0M,
  output logic nASout,
  output logic nLDSout,
  output logic nUDSout,
  output logic nVMA,
  output logic RnWout,
  output logic nDoutOE
);

  localparam int unsigned NSYNC = 5;
  // Idle level of the synchronised inputs: clocks low, bus terminations negated.
  localparam logic [NSYNC-1:0] SYNC_RST = 5'b00111;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ASRT, ST_DSTB, ST_WAIT, ST_EW0, ST_EW1, ST_EW2, ST_END, ST_REC
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            lds_req;
  logic            uds_req;

  // Two-flop synchronisers: {C8M, E, nDTACK, nVPA, nBERR}
  logic [NSYNC-1:0] sync1;
  logic [NSYNC-1:0] sync2;
  logic             c8m_prev;
  logic             e_prev;

  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      sync1    <= SYNC_RST;
      sync2    <= SYNC_RST;
      c8m_prev <= 1'b0;
      e_prev   <= 1'b0;
    end else begin
      sync1    <= {C8M, E, nDTACK, nVPA, nBERR};
      sync2    <= sync1;
      c8m_prev <= sync2[4];
      e_prev   <= sync2[3];
    end
  end

  logic c8m_s, e_s, dtack_n_s, vpa_n_s, berr_n_s;
  logic rise8, fall8, erise, efall;
  logic [CW-1:0] cnt_inc;

  assign c8m_s     = sync2[4];
  assign e_s       = sync2[3];
  assign dtack_n_s = sync2[2];
  assign vpa_n_s   = sync2[1];
  assign berr_n_s  = sync2[0];
  assign rise8     = c8m_s & ~c8m_prev;
  assign fall8     = ~c8m_s & c8m_prev;
  assign erise     = e_s & ~e_prev;
  assign efall     = ~e_s & e_prev;
  assign cnt_inc   = cnt + CW'(1);

  // Bus-cycle sequencer; every transition is gated by a C8M or E edge strobe.
  always_ff @(posedge CLK or negedge nRES) begin
    if (!nRES) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      lds_req <= 1'b0;
      uds_req <= 1'b0;
      IOACT   <= 1'b0;
      IODONE  <= 1'b0;
      IOBERR  <= 1'b0;
      ALE0M   <= 1'b0;
      nASout  <= 1'b1;
      nLDSout <= 1'b1;
      nUDSout <= 1'b1;
      nVMA    <= 1'b1;
      RnWout  <= 1'b1;
      nDoutOE <= 1'b1;
    end else begin
      IODONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rise8 && IOREQ) begin
            IOACT   <= 1'b1;
            ALE0M   <= 1'b1;
            IOBERR  <= 1'b0;
            RnWout  <= IORW;
            lds_req <= IOL0;
            uds_req <= IOU0;
            state   <= ST_ASRT;
          end
        end
        ST_ASRT: begin
          if (fall8) begin
            nASout <= 1'b0;
            // Reads strobe with AS; writes enable the data drivers first.
            if (RnWout) begin
              nLDSout <= ~lds_req;
              nUDSout <= ~uds_req;
            end else begin
              nDoutOE <= 1'b0;
            end
            state <= ST_DSTB;
          end
        end
        ST_DSTB: begin
          if (rise8) begin
            if (!RnWout) begin
              nLDSout <= ~lds_req;
              nUDSout <= ~uds_req;
            end
            cnt   <= '0;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Termination priority: bus error, then DTACK, then VPA, then timeout.
          if (fall8) begin
            if (!berr_n_s) begin
              IOBERR <= 1'b1;
              state  <= ST_END;
            end else if (!dtack_n_s) begin
              state <= ST_END;
            end else if (!vpa_n_s) begin
              state <= ST_EW0;
            end else if (cnt_inc == CW'(TIMEOUT)) begin
              IOBERR <= 1'b1;
              state  <= ST_END;
            end else begin
              cnt <= cnt_inc;
            end
          end
        end
        ST_EW0: begin
          if (efall) begin
            nVMA  <= 1'b0;
            state <= ST_EW1;
          end
        end
        ST_EW1: begin
          if (erise) begin
            state <= ST_EW2;
          end
        end
        ST_EW2: begin
          if (efall) begin
            state <= ST_END;
          end
        end
        ST_END: begin
          if (fall8) begin
            nASout  <= 1'b1;
            nLDSout <= 1'b1;
            nUDSout <= 1'b1;
            nVMA    <= 1'b1;
            nDoutOE <= 1'b1;
            IODONE  <= 1'b1;
            state   <= ST_REC;
          end
        end
        ST_REC: begin
          if (rise8) begin
            IOACT  <= 1'b0;
            ALE0M  <= 1'b0;
            RnWout <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_master.sv
`timescale 1ns/1ps
// Bench for iob_master: C8M at 6.25 MHz-ish (160 ns), E at C8M/10, CLK 100 MHz.
module tb_iob_master;

  logic CLK = 1'b0, nRES = 1'b0, C8M = 1'b0, E = 1'b0;
  logic IOREQ = 1'b0, IORW = 1'b1, IOL0 = 1'b0, IOU0 = 1'b0;
  logic nDTACK = 1'b1, nVPA = 1'b1, nBERR = 1'b1;
  logic IOACT, IODONE, IOBERR, ALE0M, nASout, nLDSout, nUDSout, nVMA, RnWout, nDoutOE;

  int n_checks = 0;
  int n_errs   = 0;
  logic exp_q[$];

  iob_master #(.TIMEOUT(128), .CW(8)) dut (
    .CLK(CLK), .nRES(nRES), .C8M(C8M), .E(E),
    .IOREQ(IOREQ), .IORW(IORW), .IOL0(IOL0), .IOU0(IOU0),
    .nDTACK(nDTACK), .nVPA(nVPA), .nBERR(nBERR),
    .IOACT(IOACT), .IODONE(IODONE), .IOBERR(IOBERR), .ALE0M(ALE0M),
    .nASout(nASout), .nLDSout(nLDSout), .nUDSout(nUDSout), .nVMA(nVMA),
    .RnWout(RnWout), .nDoutOE(nDoutOE)
  );

  always #5 CLK = ~CLK;
  initial begin #2;  forever #80  C8M = ~C8M; end
  initial begin #42; forever #800 E   = ~E;   end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // mode: 0 = DTACK after d C8M rises, 1 = VPA cycle, 2 = no termination,
  //       3 = BERR and DTACK together after d rises
  task automatic run_txn(input logic rw, input logic l, input logic u,
                         input int mode, input int d, input logic exp_berr,
                         input string nm);
    int cyc, rises, e_falls;
    logic c8m_prev, e_prev, vma_seen, e_at_vma, lds_min, uds_min, exp_v;
    realtime t_as, t_uds, t_rel;
    nDTACK = 1'b1; nBERR = 1'b1; nVPA = (mode == 1) ? 1'b0 : 1'b1;
    exp_q.push_back(exp_berr);
    @(negedge CLK);
    IORW = rw; IOL0 = l; IOU0 = u; IOREQ = 1'b1;
    cyc = 0;
    while (!IOACT && cyc < 1000) begin @(negedge CLK); cyc++; end
    check({nm, "_ioact"}, int'(IOACT), 1);
    check({nm, "_berr_clr"}, int'(IOBERR), 0);
    check({nm, "_ale"}, int'(ALE0M), 1);
    IOREQ = 1'b0;
    cyc = 0;
    while (nASout && cyc < 1000) begin @(negedge CLK); cyc++; end
    check({nm, "_as_low"}, int'(nASout), 0);
    t_as = $realtime;
    check({nm, "_rnw"}, int'(RnWout), int'(rw));
    check({nm, "_doe"}, int'(nDoutOE), int'(rw));
    check({nm, "_lds0"}, int'(nLDSout), rw ? int'(!l) : 1);
    check({nm, "_uds0"}, int'(nUDSout), rw ? int'(!u) : 1);
    c8m_prev = C8M; rises = 0; e_prev = E; e_falls = 0; vma_seen = 0; e_at_vma = 1'b1;
    lds_min = nLDSout; uds_min = nUDSout; t_uds = t_as;
    cyc = 0;
    while (!nASout && cyc < 5000) begin
      @(negedge CLK); cyc++;
      if (C8M && !c8m_prev) begin
        rises++;
        if ((mode == 0 || mode == 3) && rises == d) begin
          nDTACK = 1'b0;
          if (mode == 3) nBERR = 1'b0;
        end
      end
      c8m_prev = C8M;
      if (!nVMA && !vma_seen) begin
        vma_seen = 1'b1; e_at_vma = E;
      end else if (vma_seen && !nVMA && e_prev && !E) begin
        e_falls++;
      end
      e_prev = E;
      if (!nLDSout) lds_min = 1'b0;
      if (!nUDSout && uds_min) begin uds_min = 1'b0; t_uds = $realtime; end
    end
    t_rel = $realtime;
    check({nm, "_as_rel"}, int'(nASout), 1);
    check({nm, "_iodone"}, int'(IODONE), 1);
    check({nm, "_rel_strb"}, int'({nLDSout, nUDSout, nVMA, nDoutOE}), 15);
    check({nm, "_sb_size"}, exp_q.size(), 1);
    if (exp_q.size() > 0) begin
      exp_v = exp_q.pop_front();
      check({nm, "_ioberr"}, int'(IOBERR), int'(exp_v));
    end
    check({nm, "_lds_min"}, int'(lds_min), int'(!l));
    check({nm, "_uds_min"}, int'(uds_min), int'(!u));
    if (mode == 1) begin
      check({nm, "_vma_seen"}, int'(vma_seen), 1);
      check({nm, "_vma_on_efall"}, int'(e_at_vma), 0);
      check({nm, "_efalls"}, e_falls, 1);
    end else begin
      check({nm, "_as_dur"}, int'(t_rel - t_as), ((mode == 2) ? 129 : d + 1) * 160);
    end
    if (!rw && u) check({nm, "_uds_dly"}, int'(t_uds - t_as), 80);
    @(negedge CLK);
    check({nm, "_done_1clk"}, int'(IODONE), 0);
    cyc = 0;
    while (IOACT && cyc < 1000) begin @(negedge CLK); cyc++; end
    check({nm, "_act_drop"}, int'(IOACT), 0);
    check({nm, "_rec_dly"}, int'($realtime - t_rel), 80);
    check({nm, "_rec_out"}, int'({ALE0M, RnWout}), 1);
    check({nm, "_berr_hold"}, int'(IOBERR), int'(exp_berr));
    nDTACK = 1'b1; nBERR = 1'b1; nVPA = 1'b1;
  endtask

  initial begin
    int cyc;
    repeat (5) @(negedge CLK);
    check("rst_ctl", int'({IOACT, IODONE, IOBERR, ALE0M}), 0);
    check("rst_bus", int'({nASout, nLDSout, nUDSout, nVMA, RnWout, nDoutOE}), 63);
    nRES = 1'b1;
    repeat (40) @(negedge CLK);
    check("idle_noreq", int'(IOACT), 0);

    run_txn(1'b1, 1'b1, 1'b1, 0, 1, 1'b0, "rd_word");
    run_txn(1'b0, 1'b0, 1'b1, 0, 4, 1'b0, "wr_upper");
    run_txn(1'b1, 1'b1, 1'b0, 1, 0, 1'b0, "vpa_rd");
    run_txn(1'b1, 1'b1, 1'b1, 2, 0, 1'b1, "timeout");
    run_txn(1'b0, 1'b1, 1'b1, 3, 2, 1'b1, "berr_dtack");
    run_txn(1'b1, 1'b0, 1'b0, 0, 1, 1'b0, "as_only");

    // Reset in the middle of a WAIT state
    @(negedge CLK);
    IORW = 1'b1; IOL0 = 1'b1; IOU0 = 1'b1; IOREQ = 1'b1;
    cyc = 0;
    while (nASout && cyc < 1000) begin @(negedge CLK); cyc++; end
    check("rst_mid_as", int'(nASout), 0);
    IOREQ = 1'b0;
    repeat (60) @(negedge CLK);
    nRES = 1'b0;
    #1;
    check("rst_mid_bus", int'({nASout, nLDSout, nUDSout, nVMA, nDoutOE}), 31);
    check("rst_mid_act", int'({IOACT, ALE0M}), 0);
    repeat (10) @(negedge CLK);
    nRES = 1'b1;
    repeat (10) @(negedge CLK);
    run_txn(1'b1, 1'b1, 1'b0, 0, 2, 1'b0, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
